routing_mux_reg: RTL and testbench

- Parametrised, registered N-input data router for the microcontroller datapath.
- Selects one of `NUM_IN` handshaked sources, or the constant all-zeros / all-ones, into a single-entry output register with valid/ready flow control.
- Optional round-robin arbitration mode (compile-time, see Configuration).
- Sits between the register file / RAM / CU outputs and the consuming unit, where a plain combinational source select is no longer sufficient.

---
 rtl/routing_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/routing_mux_reg.sv | 143 ++++++++++++++
 tb/tb_routing_mux_reg.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/routing_pkg.sv
// Shared constants for the routing mux: select encoding and arbitration modes.
// WIDTH normally comes from OPERAND_SIZE in params.v; a fallback keeps standalone builds working.
`ifndef OPERAND_SIZE
`define OPERAND_SIZE 8
`endif

package routing_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    localparam int SEL_ZERO = 0;

    // Channels occupy select codes 1..n, so the all-ones constant sits just above them.
    function automatic int SEL_ONES(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: first requesting channel at or after ptr, wrapping modulo NUM_IN.
// Purely combinational; the pointer register lives in the router.
module rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any_req
);

    // Walk offsets from farthest to nearest so the closest requester after ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int off = NUM_IN - 1; off >= 0; off--) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (req[i] && ((int'(ptr) + off == i) || (int'(ptr) + off == i + NUM_IN))) begin
                    grant     = '0;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                    any_req   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/routing_mux_reg.sv
// Registered N-input router with valid/ready output stage and constant zero/ones sources.
// Define ROUTER_RR_EN to compile in round-robin arbitration selected by the mode input.
module routing_mux_reg
    import routing_pkg::*;
#(
    parameter int WIDTH  = `OPERAND_SIZE,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [SEL_W-1:0] SEL_ZERO_V = SEL_W'(SEL_ZERO);
    localparam logic [SEL_W-1:0] SEL_ONES_V = SEL_W'(SEL_ONES(NUM_IN));

    logic                   ld_ok;
    logic                   load;
    logic [WIDTH-1:0]       nxt_data;
    logic [SEL_W-1:0]       nxt_src;
    logic [NUM_IN-1:0]      rdy;

    logic                   d_load;
    logic [WIDTH-1:0]       d_data;
    logic [SEL_W-1:0]       d_src;
    logic [NUM_IN-1:0]      d_ready;

    // The output register can take a word when empty or when it drains this cycle.
    assign ld_ok = !out_valid || out_ready;

    // Direct select: constants are always valid, out-of-range codes fall back to zeros.
    always_comb begin
        d_load  = ld_ok;
        d_data  = '0;
        d_src   = SEL_ZERO_V;
        d_ready = '0;
        if (sel == SEL_ONES_V) begin
            d_data = '1;
            d_src  = SEL_ONES_V;
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k + 1)) begin
                d_load     = ld_ok && in_valid[k];
                d_data     = in_data[k*WIDTH +: WIDTH];
                d_src      = sel;
                d_ready[k] = ld_ok;
            end
        end
    end

`ifdef ROUTER_RR_EN
    localparam int IDX_W = $clog2(NUM_IN);

    logic                   rr_active;
    logic [IDX_W-1:0]       ptr;
    logic [NUM_IN-1:0]      grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   any_req;
    logic [WIDTH-1:0]       g_data;

    assign rr_active = (mode_e'(mode) == MODE_RR);

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        g_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                g_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        if (rr_active) begin
            load     = ld_ok && any_req;
            nxt_data = g_data;
            nxt_src  = SEL_W'(grant_idx) + SEL_W'(1);
            rdy      = ld_ok ? grant : '0;
        end else begin
            load     = d_load;
            nxt_data = d_data;
            nxt_src  = d_src;
            rdy      = d_ready;
        end
    end

    // The pointer only moves on an accepted round-robin transfer and survives mode switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (rr_active && load) begin
            ptr <= (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        load     = d_load;
        nxt_data = d_data;
        nxt_src  = d_src;
        rdy      = d_ready;
    end
`endif

    assign in_ready = rst ? '0 : rdy;

    // A load in the same edge as a drain simply replaces the word, keeping out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= nxt_data;
            out_src   <= nxt_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_routing_mux_reg.sv
// Self-checking bench for routing_mux_reg: directed literal checks plus a random run
// compared every cycle against a behavioural model of the router.
module tb_routing_mux_reg;

    localparam int W      = 8;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = $clog2(NUM_IN + 2);

    logic                    clk = 1'b0;
    logic                    drv_rst = 1'b1;
    logic [SEL_W-1:0]        drv_sel = '0;
    logic                    drv_mode = 1'b0;
    logic [NUM_IN*W-1:0]     drv_in_data = '0;
    logic [NUM_IN-1:0]       drv_in_valid = '0;
    logic                    drv_out_ready = 1'b1;

    logic [NUM_IN-1:0]       in_ready;
    logic [W-1:0]            out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;

    int total = 0;
    int bad   = 0;

    logic                    m_known = 1'b0;
    logic                    m_valid = 1'b0;
    logic [W-1:0]            m_data  = '0;
    logic [SEL_W-1:0]        m_src   = '0;
    int                      m_ptr   = 0;

    always #5 clk = ~clk;

    routing_mux_reg #(
        .WIDTH  (W),
        .NUM_IN (NUM_IN)
    ) dut (
        .clk       (clk),
        .rst       (drv_rst),
        .sel       (drv_sel),
        .mode      (drv_mode),
        .in_data   (drv_in_data),
        .in_valid  (drv_in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (drv_out_ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge so they are stable at the next rising edge.
    task automatic applyStimulus(input logic r, input logic [SEL_W-1:0] s, input logic m,
                                 input logic [NUM_IN-1:0] v, input logic [NUM_IN*W-1:0] d,
                                 input logic ordy);
        @(negedge clk);
        #1;
        drv_rst       = r;
        drv_sel       = s;
        drv_mode      = m;
        drv_in_valid  = v;
        drv_in_data   = d;
        drv_out_ready = ordy;
    endtask

    task automatic expectOut(input string tag, input logic ev, input logic [W-1:0] ed,
                             input logic [SEL_W-1:0] es, input logic [NUM_IN-1:0] er);
        #1;
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        checkOutput({tag, ".out_data"},  32'(out_data),  32'(ed));
        checkOutput({tag, ".out_src"},   32'(out_src),   32'(es));
        checkOutput({tag, ".in_ready"},  32'(in_ready),  32'(er));
    endtask

    // Behavioural model: decide the source from the selection rules, then advance the output word.
    always begin : ref_model
        logic               ld_ok;
        logic               rr;
        logic               e_load;
        logic [NUM_IN-1:0]  e_ready;
        logic [W-1:0]       e_data;
        logic [SEL_W-1:0]   e_src;
        int                 e_grant;
        int                 ch;

        @(negedge clk);
        #3;
        ld_ok   = !m_valid || drv_out_ready;
        e_load  = 1'b0;
        e_ready = '0;
        e_data  = '0;
        e_src   = '0;
        e_grant = -1;
        rr      = 1'b0;
`ifdef ROUTER_RR_EN
        rr = drv_mode;
`endif
        if (!rr) begin
            if (int'(drv_sel) >= 1 && int'(drv_sel) <= NUM_IN) begin
                ch          = int'(drv_sel) - 1;
                e_ready[ch] = ld_ok;
                e_load      = ld_ok && drv_in_valid[ch];
                e_data      = drv_in_data[ch*W +: W];
                e_src       = drv_sel;
            end else begin
                e_load = ld_ok;
                if (int'(drv_sel) == NUM_IN + 1) begin
                    e_data = '1;
                    e_src  = SEL_W'(NUM_IN + 1);
                end
            end
        end else begin
            for (int j = 0; j < NUM_IN; j++) begin
                if (e_grant < 0 && drv_in_valid[(m_ptr + j) % NUM_IN]) e_grant = (m_ptr + j) % NUM_IN;
            end
            if (e_grant >= 0) begin
                e_ready[e_grant] = ld_ok;
                e_load           = ld_ok;
                e_data           = drv_in_data[e_grant*W +: W];
                e_src            = SEL_W'(e_grant + 1);
            end
        end
        if (drv_rst) e_ready = '0;

        if (m_known || drv_rst) checkOutput("model.in_ready", 32'(in_ready), 32'(e_ready));
        if (m_known) begin
            checkOutput("model.out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("model.out_data",  32'(out_data),  32'(m_data));
            checkOutput("model.out_src",   32'(out_src),   32'(m_src));
        end

        @(posedge clk);
        if (drv_rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = '0;
            m_ptr   = 0;
        end else if (e_load) begin
            m_valid = 1'b1;
            m_data  = e_data;
            m_src   = e_src;
            if (rr) m_ptr = (e_grant + 1) % NUM_IN;
        end else if (drv_out_ready) begin
            m_valid = 1'b0;
        end
    end

    function automatic logic [NUM_IN*W-1:0] ch1Data(input logic [W-1:0] d);
        return {8'hC3, 8'hC2, d, 8'hC0};
    endfunction

    initial begin : stimulus
        logic [NUM_IN-1:0] rr_v   [13];
        logic              rr_rdy [13];
        logic [SEL_W-1:0]  rr_src [13];
        logic [NUM_IN-1:0] rr_er  [13];

        // Reset held two cycles with every channel offering data.
        applyStimulus(1'b1, 3'd2, 1'b0, 4'hF, ch1Data(8'h11), 1'b1);
        #1 checkOutput("reset.in_ready", 32'(in_ready), 32'h0);
        applyStimulus(1'b1, 3'd2, 1'b0, 4'hF, ch1Data(8'h11), 1'b1);
        expectOut("reset", 1'b0, 8'h00, 3'd0, 4'b0000);

        // Streaming from channel 1 (sel 2), then three cycles of backpressure.
        applyStimulus(1'b0, 3'd2, 1'b0, 4'hF, ch1Data(8'h11), 1'b1);
        expectOut("first", 1'b0, 8'h00, 3'd0, 4'b0010);
        applyStimulus(1'b0, 3'd2, 1'b0, 4'hF, ch1Data(8'h22), 1'b1);
        expectOut("stream0", 1'b1, 8'h11, 3'd2, 4'b0010);
        applyStimulus(1'b0, 3'd2, 1'b0, 4'hF, ch1Data(8'h33), 1'b1);
        expectOut("stream1", 1'b1, 8'h22, 3'd2, 4'b0010);
        applyStimulus(1'b0, 3'd2, 1'b0, 4'hF, ch1Data(8'h44), 1'b0);
        expectOut("bp0", 1'b1, 8'h33, 3'd2, 4'b0000);
        applyStimulus(1'b0, 3'd2, 1'b0, 4'hF, ch1Data(8'h44), 1'b0);
        expectOut("bp1", 1'b1, 8'h33, 3'd2, 4'b0000);
        applyStimulus(1'b0, 3'd2, 1'b0, 4'hF, ch1Data(8'h44), 1'b0);
        expectOut("bp2", 1'b1, 8'h33, 3'd2, 4'b0000);
        applyStimulus(1'b0, 3'd2, 1'b0, 4'hF, ch1Data(8'h44), 1'b1);
        expectOut("release", 1'b1, 8'h33, 3'd2, 4'b0010);

        // Constant sources and an out-of-range select.
        applyStimulus(1'b0, 3'd0, 1'b0, 4'hF, ch1Data(8'h55), 1'b1);
        expectOut("no_bubble", 1'b1, 8'h44, 3'd2, 4'b0000);
        applyStimulus(1'b0, 3'd5, 1'b0, 4'hF, ch1Data(8'h55), 1'b1);
        expectOut("const_zero", 1'b1, 8'h00, 3'd0, 4'b0000);
        applyStimulus(1'b0, 3'd7, 1'b0, 4'hF, ch1Data(8'h55), 1'b1);
        expectOut("const_ones", 1'b1, 8'hFF, 3'd5, 4'b0000);
        applyStimulus(1'b0, 3'd2, 1'b0, 4'b1101, ch1Data(8'h55), 1'b1);
        expectOut("out_of_range", 1'b1, 8'h00, 3'd0, 4'b0010);
        applyStimulus(1'b0, 3'd2, 1'b0, 4'hF, ch1Data(8'h66), 1'b1);
        expectOut("drain", 1'b0, 8'h00, 3'd0, 4'b0010);
        applyStimulus(1'b0, 3'd0, 1'b0, 4'h0, ch1Data(8'h77), 1'b1);
        expectOut("reload", 1'b1, 8'h66, 3'd2, 4'b0000);

`ifdef ROUTER_RR_EN
        // Channel k carries 0x11*(k+1), so the tag and the data both reveal the grant order.
        rr_v   = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};
        rr_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rr_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd3, 3'd4, 3'd1, 3'd3, 3'd3, 3'd3, 3'd4};
        rr_er  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001,
                   4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
        applyStimulus(1'b1, 3'd0, 1'b1, 4'hF, 32'h44332211, 1'b1);
        #1 checkOutput("rr_reset.in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b0, 3'd0, 1'b1, rr_v[i], 32'h44332211, rr_rdy[i]);
            expectOut($sformatf("rr%0d", i), (i != 0), 8'(rr_src[i] * 8'h11), rr_src[i], rr_er[i]);
        end
`endif

        // Random traffic, including mode switches, select changes and occasional resets.
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          SEL_W'($urandom_range(0, 7)),
                          ($urandom_range(0, 7) == 0) ? ~drv_mode : drv_mode,
                          NUM_IN'($urandom),
                          {$urandom},
                          ($urandom_range(0, 3) != 0));
        end
        applyStimulus(1'b0, 3'd0, 1'b0, 4'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b0, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
